// File: rtl/vc_mem_pkg.sv
// vc_mem_pkg: shared encodings for the single-port memory arbiter.
package vc_mem_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic [1:0] {CLI_I, CLI_D, CLI_X} client_t;
endpackage

// File: rtl/mem_arb.sv
// mem_arb: grants fetch, data or external master one at a time onto a single-outstanding memory bus.
module mem_arb
    import vc_mem_pkg::*;
#(
    parameter int RV = 32,
    parameter int VA = RV,
    localparam int AW = VA - RV / 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [VA-1:0]   pc,
    input  logic            ifetch,
    output logic            idone,
    input  logic [AW-1:0]   addr,
    input  logic [1:0]      rstrobe,
    input  logic [RV/8-1:0] wmask,
    input  logic [RV-1:0]   wdata,
    input  logic            io_access,
    output logic            rdone,
    output logic            wdone,
    output logic [RV-1:0]   rdata,
    input  logic            x_req,
    input  logic            x_we,
    input  logic [AW-1:0]   x_addr,
    input  logic [RV-1:0]   x_wdata,
    input  logic [RV/8-1:0] x_wmask,
    output logic            x_ack,
    output logic [RV-1:0]   x_rdata,
    output logic            m_req,
    output logic            m_we,
    output logic            m_io,
    output logic [AW-1:0]   m_addr,
    output logic [RV-1:0]   m_wdata,
    output logic [RV/8-1:0] m_wmask,
    output logic [1:0]      m_rstrobe,
    input  logic            m_ready,
    input  logic            m_rvalid,
    input  logic [RV-1:0]   m_rdata
);
    state_t  state, state_n;
    client_t cli;
    logic    last_x, d_req, d_wr, cpu_req, any_req, pick_x, unused_pc;
    assign d_wr      = |wmask;
    assign d_req     = |rstrobe || d_wr;
    assign cpu_req   = d_req || ifetch;
    assign any_req   = cpu_req || x_req;
    // Under contention the side not granted last wins; D outranks I within the CPU side.
    assign pick_x    = x_req && !(cpu_req && last_x);
    assign unused_pc = ^pc[RV/16-1:0];
    always_ff @(posedge clk)
        state <= reset ? IDLE : state_n;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = any_req ? ISSUE : IDLE;
            ISSUE:   state_n = m_ready ? (m_we ? DONE : WAIT) : ISSUE;
            WAIT:    state_n = m_rvalid ? DONE : WAIT;
            default: state_n = IDLE;
        endcase
        idone = state == DONE && cli == CLI_I;
        rdone = state == DONE && cli == CLI_D && !m_we;
        wdone = state == DONE && cli == CLI_D && m_we;
        x_ack = state == DONE && cli == CLI_X;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            last_x    <= 1'b1;
            cli       <= CLI_I;
            m_req     <= 1'b0;
            m_we      <= 1'b0;
            m_io      <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
            m_wmask   <= '0;
            m_rstrobe <= '0;
            rdata     <= '0;
            x_rdata   <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                last_x    <= pick_x;
                m_req     <= 1'b1;
                cli       <= pick_x ? CLI_X : d_req ? CLI_D : CLI_I;
                m_we      <= pick_x ? x_we : d_wr;
                m_io      <= !pick_x && d_req && io_access;
                m_addr    <= pick_x ? x_addr : d_req ? addr : pc[VA-1:RV/16];
                m_wdata   <= pick_x ? x_wdata : wdata;
                m_wmask   <= pick_x ? (x_we ? x_wmask : '0) : wmask;
                m_rstrobe <= pick_x ? (x_we ? 2'b00 : 2'b11) : !d_req ? 2'b11 : d_wr ? 2'b00 : rstrobe;
            end
            if (state == ISSUE && m_ready)
                m_req <= 1'b0;
            if (state == WAIT && m_rvalid) begin
                if (cli == CLI_X)
                    x_rdata <= m_rdata;
                else
                    rdata <= m_rdata;
            end
        end
    end
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: randomized scoreboard bench with a memory-backed bus slave and a transaction-order model.
module tb_mem_arb;
    localparam int RV = 32;
    localparam int VA = 32;
    localparam int AW = 30;
    localparam int MW = 128;

    typedef struct {
        logic          we;
        logic          io;
        logic [AW-1:0] addr;
        logic [RV-1:0] wdata;
        logic [3:0]    wmask;
        logic [1:0]    rs;
    } bus_t;
    typedef struct {
        int            kind;
        bit            has_data;
        logic [RV-1:0] data;
    } done_t;
    typedef struct {
        bit            pi, dw, dr, px, io, xwe;
        logic [VA-1:0] pc;
        logic [AW-1:0] addr, xaddr;
        logic [1:0]    rs;
        logic [3:0]    wm, xwm;
        logic [RV-1:0] wd, xwd;
    } req_t;

    logic clk = 1'b0, reset;
    logic [VA-1:0] pc;
    logic ifetch, idone, io_access, rdone, wdone, x_req, x_we, x_ack;
    logic [AW-1:0] addr, x_addr, m_addr;
    logic [1:0] rstrobe, m_rstrobe;
    logic [3:0] wmask, x_wmask, m_wmask;
    logic [RV-1:0] wdata, rdata, x_wdata, x_rdata, m_wdata, m_rdata;
    logic m_req, m_we, m_io, m_ready, m_rvalid;

    bus_t q_bus[$];
    done_t q_done[$];
    logic [RV-1:0] ref_mem[MW];
    logic [RV-1:0] bus_mem[MW];
    int checks = 0, failures = 0;
    int rw_lo = 0, rw_hi = 0, rd_lo = 0, rd_hi = 0;
    bit m_last_x;

    always #5 clk = ~clk;

    mem_arb #(.RV(RV), .VA(VA)) dut (
        .clk(clk), .reset(reset), .pc(pc), .ifetch(ifetch), .idone(idone),
        .addr(addr), .rstrobe(rstrobe), .wmask(wmask), .wdata(wdata), .io_access(io_access),
        .rdone(rdone), .wdone(wdone), .rdata(rdata),
        .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata), .x_wmask(x_wmask),
        .x_ack(x_ack), .x_rdata(x_rdata),
        .m_req(m_req), .m_we(m_we), .m_io(m_io), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wmask(m_wmask), .m_rstrobe(m_rstrobe), .m_ready(m_ready), .m_rvalid(m_rvalid),
        .m_rdata(m_rdata)
    );

    function void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [RV-1:0] merge(input logic [RV-1:0] old, input logic [RV-1:0] d, input logic [3:0] m);
        logic [RV-1:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic cmp_bus(input string tag);
        bus_t e;
        if (q_bus.size() == 0) begin
            check({tag, "_unexpected_req"}, 64'(m_req), 64'd0);
            return;
        end
        e = q_bus[0];
        check({tag, "_we"}, 64'(m_we), 64'(e.we));
        check({tag, "_io"}, 64'(m_io), 64'(e.io));
        check({tag, "_addr"}, 64'(m_addr), 64'(e.addr));
        if (e.we) begin
            check({tag, "_wdata"}, 64'(m_wdata), 64'(e.wdata));
            check({tag, "_wmask"}, 64'(m_wmask), 64'(e.wmask));
        end else
            check({tag, "_rstrobe"}, 64'(m_rstrobe), 64'(e.rs));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_m_req"}, 64'(m_req), 0);
        check({tag, "_m_we"}, 64'(m_we), 0);
        check({tag, "_m_io"}, 64'(m_io), 0);
        check({tag, "_m_addr"}, 64'(m_addr), 0);
        check({tag, "_m_wdata"}, 64'(m_wdata), 0);
        check({tag, "_m_wmask"}, 64'(m_wmask), 0);
        check({tag, "_m_rstrobe"}, 64'(m_rstrobe), 0);
        check({tag, "_pulses"}, 64'({idone, rdone, wdone, x_ack}), 0);
        check({tag, "_rdata"}, 64'(rdata), 0);
        check({tag, "_x_rdata"}, 64'(x_rdata), 0);
    endtask

    // Reference order: CPU vs X alternates by last grant, D (write before read) beats I.
    task automatic plan(input req_t r);
        bit i, dw, dr, x;
        bus_t b;
        done_t d;
        int a;
        i = r.pi; dw = r.dw; dr = r.dr; x = r.px;
        while (i || dw || dr || x) begin
            b.wdata = r.wd; b.wmask = r.wm; b.io = r.io; b.rs = 2'b11; b.we = 1'b0;
            d.has_data = 1'b1;
            if (x && (!(i || dw || dr) || !m_last_x)) begin
                a = int'(r.xaddr);
                b.we = r.xwe; b.io = 1'b0; b.addr = r.xaddr; b.wdata = r.xwd; b.wmask = r.xwm;
                d.kind = 3; d.has_data = !r.xwe; d.data = ref_mem[a];
                if (r.xwe) ref_mem[a] = merge(ref_mem[a], r.xwd, r.xwm);
                x = 0; m_last_x = 1'b1;
            end else begin
                m_last_x = 1'b0;
                if (dw) begin
                    a = int'(r.addr);
                    b.we = 1'b1; b.addr = r.addr;
                    d.kind = 2; d.has_data = 1'b0; d.data = '0;
                    ref_mem[a] = merge(ref_mem[a], r.wd, r.wm);
                    dw = 0;
                end else if (dr) begin
                    a = int'(r.addr);
                    b.addr = r.addr; b.rs = r.rs;
                    d.kind = 1; d.data = ref_mem[a];
                    dr = 0;
                end else begin
                    b.addr = r.pc[VA-1:2]; b.io = 1'b0;
                    d.kind = 0; d.data = ref_mem[int'(r.pc[VA-1:2])];
                    i = 0;
                end
            end
            q_bus.push_back(b);
            q_done.push_back(d);
        end
    endtask

    function automatic req_t rand_req();
        req_t r;
        r.pi = 1'($urandom_range(0, 1)); r.dw = 1'($urandom_range(0, 1));
        r.dr = 1'($urandom_range(0, 1)); r.px = 1'($urandom_range(0, 1));
        if (!(r.pi || r.dw || r.dr || r.px)) r.pi = 1'b1;
        r.pc = VA'($urandom_range(0, MW - 1) * 4 + $urandom_range(0, 1) * 2);
        r.addr = AW'($urandom_range(0, MW - 1));
        r.xaddr = AW'($urandom_range(0, MW - 1));
        r.rs = 2'($urandom_range(1, 3));
        r.wm = 4'($urandom_range(1, 15));
        r.xwm = 4'($urandom_range(1, 15));
        r.wd = $urandom; r.xwd = $urandom;
        r.io = 1'($urandom_range(0, 1)); r.xwe = 1'($urandom_range(0, 1));
        return r;
    endfunction

    function automatic req_t no_req();
        req_t r;
        r = rand_req();
        r.pi = 0; r.dw = 0; r.dr = 0; r.px = 0;
        return r;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        #1 reset = 1'b0;
        ifetch = 0; rstrobe = 0; wmask = 0; x_req = 0;
        q_bus.delete();
        q_done.delete();
        m_last_x = 1'b1;
        for (int k = 0; k < MW; k++) ref_mem[k] = bus_mem[k];
    endtask

    task automatic run_phase(input req_t r, input int exp_lat);
        int cyc, lat;
        plan(r);
        @(negedge clk);
        #1;
        ifetch = r.pi; pc = r.pc; addr = r.addr; wdata = r.wd; io_access = r.io;
        rstrobe = r.dr ? r.rs : 2'b00;
        wmask = r.dw ? r.wm : 4'b0000;
        x_req = r.px; x_we = r.xwe; x_addr = r.xaddr; x_wdata = r.xwd; x_wmask = r.xwm;
        cyc = 0; lat = -1;
        while ((ifetch || rstrobe != 0 || wmask != 0 || x_req) && cyc < 300) begin
            @(negedge clk);
            #1 cyc++;
            if ((idone || rdone || wdone || x_ack) && lat < 0) lat = cyc;
            if (idone) ifetch = 1'b0;
            if (rdone) rstrobe = 2'b00;
            if (wdone) wmask = 4'b0000;
            if (x_ack) x_req = 1'b0;
        end
        if (cyc >= 300) begin
            check("timeout", 1, 0);
            do_reset();
        end
        if (exp_lat > 0) check("latency", 64'(lat), 64'(exp_lat));
        repeat (2) @(negedge clk);
        check("pending_done", 64'(q_done.size()), 0);
        check("pending_bus", 64'(q_bus.size()), 0);
    endtask

    // Bus slave backed by its own memory image; also injects stray m_rvalid while idle.
    initial begin
        bit ab, we;
        int w, a;
        logic [RV-1:0] wd;
        logic [3:0] wm;
        m_ready = 0; m_rvalid = 0; m_rdata = '0;
        forever begin
            @(negedge clk);
            m_rvalid = 1'b0;
            if (!reset && m_req) begin
                ab = 0;
                w = $urandom_range(rw_hi, rw_lo);
                cmp_bus("bus");
                for (int k = 0; k < w; k++) begin
                    @(negedge clk);
                    if (reset) begin ab = 1; break; end
                    cmp_bus("bus_hold");
                end
                if (!ab) begin
                    m_ready = 1'b1;
                    a = int'(m_addr[6:0]); we = m_we; wd = m_wdata; wm = m_wmask;
                    if (q_bus.size() > 0) void'(q_bus.pop_front());
                    @(negedge clk);
                    m_ready = 1'b0;
                    if (we)
                        bus_mem[a] = merge(bus_mem[a], wd, wm);
                    else begin
                        w = $urandom_range(rd_hi, rd_lo);
                        for (int k = 0; k < w; k++) begin
                            @(negedge clk);
                            if (reset) begin ab = 1; break; end
                        end
                        if (!ab) begin
                            m_rvalid = 1'b1;
                            m_rdata = bus_mem[a];
                        end
                    end
                end
            end else if (!reset && $urandom_range(0, 3) == 0) begin
                m_rvalid = 1'b1;
                m_rdata = $urandom;
            end
        end
    end

    initial begin
        int n, k;
        done_t d;
        forever begin
            @(negedge clk);
            n = int'(idone) + int'(rdone) + int'(wdone) + int'(x_ack);
            if (n > 1)
                check("one_pulse", 64'(n), 1);
            else if (n == 1 && q_done.size() == 0)
                check("unexpected_done", 64'({idone, rdone, wdone, x_ack}), 0);
            else if (n == 1) begin
                d = q_done.pop_front();
                k = idone ? 0 : rdone ? 1 : wdone ? 2 : 3;
                check("done_kind", 64'(k), 64'(d.kind));
                if (d.has_data && k < 2) check("rdata", 64'(rdata), 64'(d.data));
                if (d.has_data && k == 3) check("x_rdata", 64'(x_rdata), 64'(d.data));
            end
        end
    end

    initial begin
        req_t r;
        int cyc;
        reset = 1; ifetch = 0; pc = '0; addr = '0; rstrobe = 0; wmask = 0; wdata = '0; io_access = 0;
        x_req = 0; x_we = 0; x_addr = '0; x_wdata = '0; x_wmask = 0;
        for (int i = 0; i < MW; i++) begin
            ref_mem[i] = $urandom;
            bus_mem[i] = ref_mem[i];
        end
        m_last_x = 1'b1;
        repeat (3) @(negedge clk);
        check_reset("por");
        #1 reset = 0;
        // CPU wins the first contention, then X.
        r = no_req(); r.pi = 1; r.px = 1; r.xwe = 0;
        run_phase(r, 0);
        r = no_req(); r.pi = 1; r.pc = 32'h100;
        run_phase(r, 3);
        r = no_req(); r.pi = 1; r.dr = 1; r.rs = 2'b01;
        run_phase(r, 0);
        r = no_req(); r.dw = 1; r.px = 1; r.xwe = 1;
        run_phase(r, 0);
        r = no_req(); r.dw = 1; r.wm = 4'b0011;
        run_phase(r, 2);
        rw_lo = 5; rw_hi = 5;
        r = no_req(); r.dw = 1; r.wm = 4'b0011;
        run_phase(r, 7);
        rw_lo = 0; rw_hi = 0; rd_lo = 7; rd_hi = 7;
        r = no_req(); r.dr = 1; r.rs = 2'b10;
        run_phase(r, 10);
        r = no_req(); r.dw = 1; r.dr = 1; r.pi = 1; r.px = 1;
        run_phase(r, 0);
        // Abandon a read in WAIT with reset.
        rd_lo = 20; rd_hi = 20;
        r = no_req(); r.dr = 1; r.rs = 2'b01;
        plan(r);
        @(negedge clk);
        #1 rstrobe = r.rs; addr = r.addr; io_access = 0;
        cyc = 0;
        while (!m_req && cyc < 10) begin @(negedge clk); cyc++; end
        while (m_req && cyc < 20) begin @(negedge clk); cyc++; end
        check("midrd_reached_wait", 64'(cyc < 20 && cyc > 0), 1);
        #1 reset = 1;
        @(negedge clk);
        check_reset("midrd");
        #1 reset = 0; rstrobe = 0;
        q_done.delete();
        q_bus.delete();
        m_last_x = 1'b1;
        repeat (25) @(negedge clk);
        rd_lo = 0; rd_hi = 3; rw_lo = 0; rw_hi = 3;
        r = no_req(); r.pi = 1; r.px = 1;
        run_phase(r, 0);
        repeat (60) run_phase(rand_req(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
